// File: rtl/dummy_adc_seq_if.sv
// Control/result bundle between the bus ADC wrapper (master) and the
// conversion sequencer (slave).
interface dummy_adc_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic                         ADC_TRIGGER;
    logic                         ABORT;
    logic [1:0]                   MODE;
    logic [CH_W-1:0]              CH_SEL;
    logic [NUM_CH-1:0]            CH_ENABLE;
    logic                         STATUS_CLR;
    logic [NUM_CH*DATA_WIDTH-1:0] ANALOG_IN;
    logic [DATA_WIDTH-1:0]        MEASUREMENT;
    logic [CH_W-1:0]              MEAS_CHANNEL;
    logic                         MEAS_VALID;
    logic                         SEQ_DONE;
    logic                         BUSY;
    logic                         OVERRUN;
    logic [31:0]                  STATUS_REG;

    modport master (
        output ADC_TRIGGER, ABORT, MODE, CH_SEL, CH_ENABLE, STATUS_CLR, ANALOG_IN,
        input  MEASUREMENT, MEAS_CHANNEL, MEAS_VALID, SEQ_DONE, BUSY, OVERRUN, STATUS_REG
    );

    modport slave (
        input  ADC_TRIGGER, ABORT, MODE, CH_SEL, CH_ENABLE, STATUS_CLR, ANALOG_IN,
        output MEASUREMENT, MEAS_CHANNEL, MEAS_VALID, SEQ_DONE, BUSY, OVERRUN, STATUS_REG
    );
endinterface

// File: rtl/dummy_adc_seq.sv
// Multi-channel behavioural ADC with single / scan-once / continuous sequencing,
// fixed per-channel conversion latency and a packed status word.
module dummy_adc_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CH      = 4,
    parameter int RESOLUTION  = 12,
    parameter int CONV_CYCLES = 16
) (
    input  logic           CLK,
    input  logic           RST,
    dummy_adc_seq_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SAMPLE  = 2'd1;
    localparam logic [1:0] S_CONVERT = 2'd2;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_CH-1:0]     r_mask;
    logic                  r_cont;
    logic [CH_W-1:0]       r_ch;
    logic [DATA_WIDTH-1:0] r_sample;
    logic [DATA_WIDTH-1:0] r_meas;
    logic [CH_W-1:0]       r_meas_ch;
    logic                  r_valid;
    logic                  r_done;
    logic                  r_ovr;
    logic [15:0]           r_count;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_ain;
    logic [NUM_CH-1:0]     w_start_mask;
    logic [CH_W-1:0]       w_first_ch;
    logic                  w_first_vld;
    logic [CH_W-1:0]       w_next_ch;
    logic                  w_next_vld;
    logic [CH_W-1:0]       w_wrap_ch;
    logic [DATA_WIDTH-1:0] w_samp;
    logic                  w_busy;
    logic                  w_ovr_set;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ain
        assign w_ain[g] = bus.ANALOG_IN[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_busy    = (r_state != S_IDLE);
    assign w_ovr_set = w_busy && bus.ADC_TRIGGER && !bus.ABORT;

    // Single mode is folded into the scan path as a one-hot mask.
    always_comb begin
        w_start_mask = (bus.MODE == 2'b00) ? (NUM_CH'(1) << bus.CH_SEL) : bus.CH_ENABLE;
        w_first_ch  = '0;
        w_first_vld = 1'b0;
        w_next_ch   = '0;
        w_next_vld  = 1'b0;
        w_wrap_ch   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_start_mask[i]) begin
                w_first_ch  = CH_W'(i);
                w_first_vld = 1'b1;
            end
            if (r_mask[i] && (CH_W'(i) > r_ch)) begin
                w_next_ch  = CH_W'(i);
                w_next_vld = 1'b1;
            end
            if (r_mask[i]) w_wrap_ch = CH_W'(i);
        end
        w_samp = '0;
        w_samp[RESOLUTION-1:0] = w_ain[r_ch][RESOLUTION-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mask    <= '0;
            r_cont    <= 1'b0;
            r_ch      <= '0;
            r_sample  <= '0;
            r_meas    <= '0;
            r_meas_ch <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
            r_count   <= '0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (w_ovr_set)          r_ovr <= 1'b1;
            else if (bus.STATUS_CLR) r_ovr <= 1'b0;

            if (w_busy && bus.ABORT) begin
                r_state <= S_IDLE;
                r_ch    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.ADC_TRIGGER && !bus.ABORT) begin
                            r_mask <= w_start_mask;
                            r_cont <= (bus.MODE == 2'b10);
                            if (w_first_vld) begin
                                r_state <= S_SAMPLE;
                                r_ch    <= w_first_ch;
                            end else begin
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_SAMPLE: begin
                        r_sample <= w_samp;
                        r_cnt    <= CNT_W'(CONV_CYCLES - 1);
                        r_state  <= S_CONVERT;
                    end
                    S_CONVERT: begin
                        if (r_cnt == '0) begin
                            r_meas    <= r_sample;
                            r_meas_ch <= r_ch;
                            r_valid   <= 1'b1;
                            r_count   <= r_count + 16'd1;
                            if (w_next_vld) begin
                                r_ch    <= w_next_ch;
                                r_state <= S_SAMPLE;
                            end else if (r_cont) begin
                                r_ch    <= w_wrap_ch;
                                r_state <= S_SAMPLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_ch    <= '0;
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.MEASUREMENT  = r_meas;
    assign bus.MEAS_CHANNEL = r_meas_ch;
    assign bus.MEAS_VALID   = r_valid;
    assign bus.SEQ_DONE     = r_done;
    assign bus.BUSY         = w_busy;
    assign bus.OVERRUN      = r_ovr;
    // r_ch is cleared whenever the sequencer drops to IDLE, so no gating here.
    assign bus.STATUS_REG   = {r_count, {(8 - CH_W){1'b0}}, r_ch, 6'b0, r_ovr, w_busy};
endmodule
